// File: rtl/tmds_channel_decoder_pkg.sv
// tmds_channel_decoder_pkg: TMDS symbol widths, control tokens and aligner state shared by both link ends
package tmds_channel_decoder_pkg;
    localparam int TMDS_SYMBOL_W = 10;
    localparam int TMDS_DATA_W = 8;
    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_TOKEN_0 = 10'h354;
    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_TOKEN_1 = 10'h0AB;
    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_TOKEN_2 = 10'h154;
    localparam logic [TMDS_SYMBOL_W-1:0] CTRL_TOKEN_3 = 10'h2AB;
    typedef enum logic {SEARCH, LOCKED} alignState;
    function automatic logic [1:0] tokenToCtrl(input logic [TMDS_SYMBOL_W-1:0] token);
        return token == CTRL_TOKEN_1 ? 2'b01 : token == CTRL_TOKEN_2 ? 2'b10 : token == CTRL_TOKEN_3 ? 2'b11 : 2'b00;
    endfunction
endpackage

// File: rtl/tmds_channel_decoder_symbol_decode.sv
// tmds_symbol_decode: classifies one aligned 10-bit TMDS symbol and undoes the XOR/XNOR and inversion stages
module tmds_symbol_decode
    import tmds_channel_decoder_pkg::*;
(
    input  logic [TMDS_SYMBOL_W-1:0] symbol,
    output logic                     isCtrl,
    output logic [1:0]               ctrl,
    output logic [TMDS_DATA_W-1:0]   data
);
    logic [TMDS_DATA_W-1:0] dPrime;
    assign isCtrl = symbol inside {CTRL_TOKEN_0, CTRL_TOKEN_1, CTRL_TOKEN_2, CTRL_TOKEN_3};
    assign ctrl = tokenToCtrl(symbol);
    assign dPrime = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    assign data = {symbol[8] ? dPrime[7:1] ^ dPrime[6:0] : ~(dPrime[7:1] ^ dPrime[6:0]), dPrime[0]};
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: bitslip word aligner and symbol decoder for one TMDS data channel
module tmds_channel_decoder
    import tmds_channel_decoder_pkg::*;
#(
    parameter int LOCK_TOKENS = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic                     pixelClock,
    input  logic                     reset,
    input  logic [TMDS_SYMBOL_W-1:0] rawWord,
    output logic [TMDS_DATA_W-1:0]   dataOut,
    output logic [1:0]               ctrlOut,
    output logic                     dataEnable,
    output logic                     locked,
    output logic [3:0]               alignOffset
);
    localparam int TW = $clog2(LOCK_TOKENS) + 1;
    localparam int SW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int LW = $clog2(LOSS_TIMEOUT) + 1;
    alignState state, nextState;
    logic [TMDS_SYMBOL_W-1:0] rawReg, prevReg, symbol;
    logic [3:0] offset, nextOffset;
    logic [TW-1:0] tokenRun, nextTokenRun;
    logic [SW-1:0] searchTimer, nextSearchTimer;
    logic [LW-1:0] lossTimer, nextLossTimer;
    logic isCtrl, slip, slipDelay, nextEnable;
    logic [1:0] ctrl, nextCtrl;
    logic [TMDS_DATA_W-1:0] data;

    // prevReg holds the earlier word, so low window bits are earliest on the wire
    assign symbol = TMDS_SYMBOL_W'({rawReg, prevReg} >> offset);
    assign locked = state == LOCKED;
    assign alignOffset = offset;

    tmds_symbol_decode symbolDecode (.symbol(symbol), .isCtrl(isCtrl), .ctrl(ctrl), .data(data));

    always_comb begin
        nextState = state;
        nextTokenRun = '0;
        nextSearchTimer = '0;
        nextLossTimer = '0;
        slip = 1'b0;
        if (state == SEARCH) begin
            if (isCtrl && tokenRun == TW'(LOCK_TOKENS - 1))
                nextState = LOCKED;
            else if (searchTimer == SW'(SEARCH_TIMEOUT - 1))
                slip = 1'b1;
            else begin
                nextTokenRun = isCtrl ? tokenRun + 1'b1 : '0;
                nextSearchTimer = searchTimer + 1'b1;
            end
        end else if (!isCtrl && lossTimer == LW'(LOSS_TIMEOUT - 1)) begin
            nextState = SEARCH;
            slip = 1'b1;
        end else
            nextLossTimer = isCtrl ? '0 : lossTimer + 1'b1;
        nextOffset = !slip ? offset : offset == 4'd9 ? 4'd0 : offset + 4'd1;
        // outputs follow the state being entered so locked and the first token appear together
        nextEnable = nextState == LOCKED && !isCtrl && !slipDelay;
        nextCtrl = nextState == SEARCH ? 2'b00 : isCtrl ? ctrl : ctrlOut;
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            rawReg <= '0;
            prevReg <= '0;
            state <= SEARCH;
            offset <= '0;
            tokenRun <= '0;
            searchTimer <= '0;
            lossTimer <= '0;
            slipDelay <= 1'b0;
            dataOut <= '0;
            ctrlOut <= '0;
            dataEnable <= 1'b0;
        end else begin
            rawReg <= rawWord;
            prevReg <= rawReg;
            state <= nextState;
            offset <= nextOffset;
            tokenRun <= nextTokenRun;
            searchTimer <= nextSearchTimer;
            lossTimer <= nextLossTimer;
            slipDelay <= slip;
            dataOut <= nextEnable ? data : '0;
            ctrlOut <= nextCtrl;
            dataEnable <= nextEnable;
        end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed checks of alignment, lock/loss and symbol decoding for one TMDS channel
module tb_tmds_channel_decoder;
    logic pixelClock = 1'b0;
    logic reset = 1'b1;
    logic [9:0] rawWord = '0;
    logic [7:0] dataOut;
    logic [1:0] ctrlOut;
    logic dataEnable, locked;
    logic [3:0] alignOffset;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int skew = 0;
    int zeroDe = 0;
    logic [9:0] prevSym = '0;
    logic [9:0] code;

    tmds_channel_decoder dut (
        .pixelClock(pixelClock), .reset(reset), .rawWord(rawWord), .dataOut(dataOut),
        .ctrlOut(ctrlOut), .dataEnable(dataEnable), .locked(locked), .alignOffset(alignOffset)
    );

    always #5 pixelClock = ~pixelClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input string tag);
        chk({tag, "_data"}, 32'(dataOut), 0);
        chk({tag, "_ctrl"}, 32'(ctrlOut), 0);
        chk({tag, "_de"}, 32'(dataEnable), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_offset"}, 32'(alignOffset), 0);
    endtask

    // serialise symbols LSB-first with 'skew' junk bits ahead of the first symbol
    task automatic send(input logic [9:0] sym);
        logic [19:0] pair;
        pair = {sym, prevSym} >> (10 - skew);
        rawWord = pair[9:0];
        prevSym = sym;
        @(posedge pixelClock);
        #1;
        cyc++;
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        rawWord = '0;
        prevSym = '0;
        repeat (2) @(posedge pixelClock);
        #1;
        idle(tag);
        reset = 1'b0;
        cyc = 0;
    endtask

    function automatic logic isToken(input logic [9:0] q);
        return q == 10'h354 || q == 10'h0AB || q == 10'h154 || q == 10'h2AB;
    endfunction

    function automatic logic [1:0] goldCtrl(input logic [9:0] q);
        case (q)
            10'h0AB: return 2'd1;
            10'h154: return 2'd2;
            10'h2AB: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] goldData(input logic [9:0] q);
        logic [7:0] dp, d;
        dp = q[9] ? ~q[7:0] : q[7:0];
        d[0] = dp[0];
        for (int i = 1; i < 8; i++) d[i] = q[8] ? dp[i] ^ dp[i-1] : ~(dp[i] ^ dp[i-1]);
        return d;
    endfunction

    initial begin
        doReset("por");
        skew = 0;
        for (int i = 1; i <= 12; i++) begin
            send(10'h354);
            if (i == 9) chk("lock_before_8th", 32'(locked), 0);
            if (i == 10) begin
                chk("lock_after_8th", 32'(locked), 1);
                chk("aligned_ctrl", 32'(ctrlOut), 0);
                chk("aligned_offset", 32'(alignOffset), 0);
                chk("aligned_token_de", 32'(dataEnable), 0);
            end
        end
        send(10'h100);
        send(10'h2FF);
        chk("last_token_de", 32'(dataEnable), 0);
        send(10'h2AB);
        chk("d100_de", 32'(dataEnable), 1);
        chk("d100_data", 32'(dataOut), 32'h00);
        send(10'h100);
        chk("d2ff_de", 32'(dataEnable), 1);
        chk("d2ff_data", 32'(dataOut), 32'hFE);
        send(10'h100);
        chk("tok11_de", 32'(dataEnable), 0);
        chk("tok11_data", 32'(dataOut), 0);
        chk("tok11_ctrl", 32'(ctrlOut), 3);
        send(10'h100);
        chk("ctrl_hold_de", 32'(dataEnable), 1);
        chk("ctrl_hold", 32'(ctrlOut), 3);

        for (int i = 0; i < 1026; i++) begin
            send(i < 1024 ? 10'(i) : 10'h100);
            if (i >= 2) begin
                code = 10'(i - 2);
                if (dataEnable === 1'b0) zeroDe++;
                if (isToken(code)) begin
                    chk($sformatf("sweep_%03h_de", code), 32'(dataEnable), 0);
                    chk($sformatf("sweep_%03h_data", code), 32'(dataOut), 0);
                    chk($sformatf("sweep_%03h_ctrl", code), 32'(ctrlOut), 32'(goldCtrl(code)));
                end else begin
                    chk($sformatf("sweep_%03h_de", code), 32'(dataEnable), 1);
                    chk($sformatf("sweep_%03h_data", code), 32'(dataOut), 32'(goldData(code)));
                end
            end
        end
        chk("sweep_zero_de_count", 32'(zeroDe), 4);

        chk("pre_reset_locked", 32'(locked), 1);
        chk("pre_reset_de", 32'(dataEnable), 1);
        #2 reset = 1'b1;
        #1 idle("mid_reset");
        @(posedge pixelClock);
        #1;
        idle("held_reset");
        reset = 1'b0;
        cyc = 0;
        prevSym = '0;
        repeat (20) send(10'h100);
        chk("post_reset_locked", 32'(locked), 0);
        chk("post_reset_de", 32'(dataEnable), 0);

        doReset("brk_reset");
        repeat (7) send(10'h154);
        send(10'h100);
        repeat (7) send(10'h154);
        send(10'h100);
        send(10'h100);
        chk("brk_locked_early", 32'(locked), 0);
        while (cyc < 2047) send(10'h100);
        chk("brk_locked", 32'(locked), 0);
        chk("brk_offset_pre", 32'(alignOffset), 0);
        send(10'h100);
        chk("brk_offset_slip", 32'(alignOffset), 1);
        chk("brk_locked_slip", 32'(locked), 0);

        doReset("mis_reset");
        skew = 3;
        for (int t = 1; t <= 6412; t++) begin
            send(((t - 1) % 800) < 16 ? 10'h0AB : 10'h100);
            if (t == 2047) chk("mis_off_2047", 32'(alignOffset), 0);
            if (t == 2048) chk("mis_off_2048", 32'(alignOffset), 1);
            if (t == 2049) chk("mis_slip_de", 32'(dataEnable), 0);
            if (t == 4095) chk("mis_off_4095", 32'(alignOffset), 1);
            if (t == 4096) chk("mis_off_4096", 32'(alignOffset), 2);
            if (t == 6143) chk("mis_off_6143", 32'(alignOffset), 2);
            if (t == 6144) chk("mis_off_6144", 32'(alignOffset), 3);
            if (t == 6409) chk("mis_lock_early", 32'(locked), 0);
            if (t == 6410) begin
                chk("mis_lock", 32'(locked), 1);
                chk("mis_lock_ctrl", 32'(ctrlOut), 1);
                chk("mis_lock_offset", 32'(alignOffset), 3);
            end
            if (t == 6412) chk("mis_token_de", 32'(dataEnable), 0);
        end

        doReset("loss_reset");
        skew = 9;
        while (!locked && cyc < 20000) send(10'h354);
        chk("loss_lock", 32'(locked), 1);
        chk("loss_lock_cycle", 32'(cyc), 18440);
        chk("loss_lock_offset", 32'(alignOffset), 9);
        for (int k = 1; k <= 4097; k++) send(10'h100);
        chk("loss_still_locked", 32'(locked), 1);
        chk("loss_data_de", 32'(dataEnable), 1);
        chk("loss_data", 32'(dataOut), 0);
        chk("loss_offset_pre", 32'(alignOffset), 9);
        send(10'h100);
        chk("loss_unlocked", 32'(locked), 0);
        chk("loss_offset_wrap", 32'(alignOffset), 0);
        chk("loss_de", 32'(dataEnable), 0);
        repeat (3) send(10'h100);
        chk("loss_de_after", 32'(dataEnable), 0);
        chk("loss_locked_after", 32'(locked), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
